shift_serializer: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a `load` handshake and drives it onto a single serial output, one bit per clock. It is the transmit end of the team's loadable-register datapath: a `load`/`d` word goes in, and a framed bit stream with `q_valid`/`last` qualifiers comes out for a downstream deserializer. It supports stall (`hold`), synchronous abort (`clear`) and a completion pulse.

---
 rtl/shift_serializer_pkg.sv | 17 +
 rtl/shift_bit_counter.sv | 42 ++++
 rtl/shift_serializer.sv | 157 +++++++++++++++
 tb/tb_shift_serializer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package shift_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Output values after reset and after an abort
    localparam logic RST_READY   = 1'b1;
    localparam logic RST_Q       = 1'b0;
    localparam logic RST_Q_VALID = 1'b0;
    localparam logic RST_LAST    = 1'b0;
    localparam logic RST_DONE    = 1'b0;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the serializer: counts the bits already sent
// and flags the final bit position of a WIDTH-bit frame.
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    output logic [$clog2(WIDTH)-1:0] count_o,
    output logic                     tc_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over enable so a new frame always starts from position zero
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset to zero
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST_IDX);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter. A word accepted on load is sent one
// bit per clock with q_valid/last qualifiers, followed by a one-cycle done
// pulse. Supports stalling with hold and aborting with clear.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             hold,
    input  logic             clear,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

    state_e state_q;
    state_e state_d;

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shifted;

    logic ready_q, ready_d;
    logic q_q, q_d;
    logic q_valid_q, q_valid_d;
    logic last_q, last_d;
    logic done_q, done_d;

    logic          accept;
    logic          advance;
    logic          cntEn;
    logic          cntClr;
    logic [CW-1:0] cnt;
    logic          cntTc;

    assign accept  = (state_q == ST_IDLE) && load && !clear;
    assign advance = (state_q == ST_SHIFT) && !hold;
    assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // The counter restarts on every new word, on abort and when the frame ends
    assign cntClr = clear || accept || (advance && cntTc);
    assign cntEn  = advance;

    shift_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clock_i (clock),
        .reset_ni(reset),
        .en_i    (cntEn),
        .clr_i   (cntClr),
        .count_o (cnt),
        .tc_o    (cntTc)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (load) state_d = ST_SHIFT;
                ST_SHIFT: if (!hold && cntTc) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the shift register and the registered outputs
    always_comb begin
        shreg_d   = shreg_q;
        ready_d   = RST_READY;
        q_d       = RST_Q;
        q_valid_d = RST_Q_VALID;
        last_d    = RST_LAST;
        done_d    = RST_DONE;
        if (!clear) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        shreg_d   = d;
                        ready_d   = 1'b0;
                        q_d       = MSB_FIRST ? d[WIDTH-1] : d[0];
                        q_valid_d = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    ready_d = 1'b0;
                    if (hold) begin
                        q_d       = q_q;
                        q_valid_d = 1'b1;
                        last_d    = last_q;
                    end else if (cntTc) begin
                        done_d = 1'b1;
                    end else begin
                        shreg_d   = shifted;
                        q_d       = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
                        q_valid_d = 1'b1;
                        last_d    = (cnt == PRE_LAST_IDX);
                    end
                end
                ST_DONE: begin
                    ready_d = 1'b1;
                end
                default: begin
                    ready_d = RST_READY;
                end
            endcase
        end
    end

    // Datapath and output registers, cleared asynchronously so a reset drops the frame at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q   <= '0;
            ready_q   <= RST_READY;
            q_q       <= RST_Q;
            q_valid_q <= RST_Q_VALID;
            last_q    <= RST_LAST;
            done_q    <= RST_DONE;
        end else begin
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign last    = last_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: an MSB-first and an LSB-first instance share
// stimulus; a frame-level model predicts every output cycle, and directed
// literal expectations pin the model on the reference frames.
module tb_shift_serializer;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         load;
    logic [W-1:0] d;
    logic         hold;
    logic         clear;

    logic readyM, qM, qValidM, lastM, doneM;
    logic readyL, qL, qValidL, lastL, doneL;

    int checks;
    int failures;
    bit chkEn;

    // Model state: frame in progress, done cycle, word and current bit index
    bit           mBusy;
    bit           mDonePh;
    logic [W-1:0] mWord;
    int           mIdx;

    // Capture of what the MSB-first and LSB-first instances put on the wire
    logic [31:0] capMsb;
    logic [31:0] capLsb;
    int          capValid;
    int          capLast;
    int          capDone;

    shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .d      (d),
        .hold   (hold),
        .clear  (clear),
        .ready  (readyM),
        .q      (qM),
        .q_valid(qValidM),
        .last   (lastM),
        .done   (doneM)
    );

    shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .d      (d),
        .hold   (hold),
        .clear  (clear),
        .ready  (readyL),
        .q      (qL),
        .q_valid(qValidL),
        .last   (lastL),
        .done   (doneL)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Frame-level model: idle, busy sending bit mIdx of mWord, or one done cycle
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mBusy   = 1'b0;
            mDonePh = 1'b0;
            mIdx    = 0;
            mWord   = '0;
        end else if (clear) begin
            mBusy   = 1'b0;
            mDonePh = 1'b0;
        end else if (mDonePh) begin
            mDonePh = 1'b0;
        end else if (mBusy) begin
            if (!hold) begin
                if (mIdx == W - 1) begin
                    mBusy   = 1'b0;
                    mDonePh = 1'b1;
                end else begin
                    mIdx = mIdx + 1;
                end
            end
        end else if (load) begin
            mBusy = 1'b1;
            mIdx  = 0;
            mWord = d;
        end
    end

    // Expected {ready, q, q_valid, last, done} for the given bit order
    function automatic logic [4:0] expOut(bit msbFirst);
        logic bitVal;
        bitVal = 1'b0;
        if (mBusy) bitVal = msbFirst ? mWord[W-1-mIdx] : mWord[mIdx];
        return {!mBusy && !mDonePh, bitVal, mBusy, mBusy && (mIdx == W - 1), mDonePh};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (chkEn) begin
            checkOutput("cycleMsb", {27'd0, readyM, qM, qValidM, lastM, doneM}, {27'd0, expOut(1'b1)});
            checkOutput("cycleLsb", {27'd0, readyL, qL, qValidL, lastL, doneL}, {27'd0, expOut(1'b0)});
        end
    end

    // Record the serial streams and qualifier counts
    always @(negedge clock) begin
        if (qValidM) begin
            capMsb   = {capMsb[30:0], qM};
            capValid = capValid + 1;
        end
        if (qValidL) capLsb = {capLsb[30:0], qL};
        if (lastM) capLast = capLast + 1;
        if (doneM) capDone = capDone + 1;
    end

    task automatic clearCapture();
        capMsb   = '0;
        capLsb   = '0;
        capValid = 0;
        capLast  = 0;
        capDone  = 0;
    endtask

    task automatic applyStimulus(input logic ld, input logic [W-1:0] dv, input logic hd, input logic cl);
        load  = ld;
        d     = dv;
        hold  = hd;
        clear = cl;
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [7:0] refWord;
    logic [4:0] lit;

    initial begin
        checks   = 0;
        failures = 0;
        chkEn    = 1'b0;
        clearCapture();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chkEn = 1'b1;
        checkOutput("resetMsb", {27'd0, readyM, qM, qValidM, lastM, doneM}, 32'h10);
        checkOutput("resetLsb", {27'd0, readyL, qL, qValidL, lastL, doneL}, 32'h10);
        step(2);
        reset = 1'b1;
        step(2);

        // Reference frame A5, with a cycle-by-cycle literal table
        refWord = 8'hA5;
        clearCapture();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            lit = {k == 10, (k <= 8) ? refWord[8-k] : 1'b0, k <= 8, k == 8, k == 9};
            checkOutput($sformatf("a5Cycle%0d", k), {27'd0, readyM, qM, qValidM, lastM, doneM}, {27'd0, lit});
        end
        step(1);
        checkOutput("a5StreamMsb", capMsb, 32'hA5);
        checkOutput("a5StreamLsb", capLsb, 32'hA5);
        checkOutput("a5Valid", capValid, 8);
        checkOutput("a5Last", capLast, 1);
        checkOutput("a5Done", capDone, 1);

        // C1: LSB-first order is reversed
        clearCapture();
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(11);
        checkOutput("c1StreamLsb", capLsb, 32'b10000011);
        checkOutput("c1StreamMsb", capMsb, 32'hC1);
        checkOutput("c1Done", capDone, 1);

        // A5 with hold for 3 edges while the third bit is on q
        clearCapture();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step(3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(10);
        checkOutput("holdStream", capMsb, 32'b10111100101);
        checkOutput("holdValid", capValid, 11);
        checkOutput("holdDone", capDone, 1);

        // Load of FF during the 4th bit of a 00 frame is ignored
        clearCapture();
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(3);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(8);
        checkOutput("ignoreStream", capMsb, 32'h00);
        checkOutput("ignoreValid", capValid, 8);
        clearCapture();
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(11);
        checkOutput("ffStream", capMsb, 32'hFF);
        checkOutput("ffValid", capValid, 8);

        // Clear during the 5th bit
        clearCapture();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("clearOuts", {27'd0, readyM, qM, qValidM, lastM, doneM}, 32'h10);
        step(10);
        checkOutput("clearDone", capDone, 0);
        checkOutput("clearValid", capValid, 5);
        checkOutput("clearPartial", capMsb, 32'b10100);

        // Clear together with load in IDLE: word rejected
        clearCapture();
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(4);
        checkOutput("clearLoadValid", capValid, 0);
        checkOutput("clearLoadReady", {31'd0, readyM}, 32'd1);

        // Asynchronous reset mid-frame, then a clean 5A frame
        clearCapture();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(3);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncRstMsb", {27'd0, readyM, qM, qValidM, lastM, doneM}, 32'h10);
        checkOutput("asyncRstLsb", {27'd0, readyL, qL, qValidL, lastL, doneL}, 32'h10);
        step(2);
        reset = 1'b1;
        step(1);
        clearCapture();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step(11);
        checkOutput("postRstStream", capMsb, 32'h5A);
        checkOutput("postRstLsb", capLsb, 32'b01011010);
        checkOutput("postRstDone", capDone, 1);

        chkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
